// File: rtl/eth_rx_pkg.sv
// Shared definitions for the RMII receive path: state encodings, SFD marker
// and the dibit assembly helper.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } rx_state_t;

    // Final dibit of the 0xD5 start-of-frame delimiter, as seen LSB-first.
    localparam logic [1:0] SFD_DIBIT = 2'b11;

    // Dibits arrive LSB-first, so each new one enters at the top and the
    // first dibit of a byte ends up in bits [1:0] after four shifts.
    function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic [1:0] dib);
        return {dib, sh[7:2]};
    endfunction

endpackage

// File: rtl/eth_rx_r.sv
// Generic enabled register with asynchronous active-high reset.
module r #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             c,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/eth_rx.sv
// RMII receiver: hunts for the SFD, assembles LSB-first dibits into bytes and
// strobes each complete byte plus a single end-of-frame pulse.
module eth_rx
    import eth_rx_pkg::*;
(
    input  logic       c,
    input  logic       rst,
    input  logic [1:0] phy_rxd,
    input  logic       phy_rxdv,
    output logic [7:0] d,
    output logic       dv,
    output logic       erx
);

    localparam logic [1:0] IDLE_BITS = IDLE;

    logic [1:0] state_bits;
    rx_state_t  state;
    rx_state_t  state_next;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic       shift_en;
    logic [1:0] cnt_reg;
    logic [1:0] cnt_next;
    logic       byte_done;
    logic       erx_next;
    logic       rxdv_prev_reg;

    assign state = rx_state_t'(state_bits);

    always_comb begin
        state_next = state;
        shift_next = shift_in(shift_reg, phy_rxd);
        shift_en   = 1'b0;
        cnt_next   = cnt_reg;
        byte_done  = 1'b0;
        erx_next   = 1'b0;
        case (state)
            IDLE: begin
                // Requiring a low-to-high carrier edge keeps us from locking
                // onto the middle of a frame that was in flight during reset.
                if (phy_rxdv && !rxdv_prev_reg) begin
                    state_next = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (!phy_rxdv) begin
                    state_next = IDLE;
                end else if (phy_rxd == SFD_DIBIT) begin
                    cnt_next   = 2'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (phy_rxdv) begin
                    shift_en  = 1'b1;
                    cnt_next  = cnt_reg + 2'd1;
                    byte_done = (cnt_reg == 2'd3);
                end else begin
                    // Any partially assembled byte is simply dropped here.
                    erx_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    r #(.WIDTH(2), .RST_VAL(IDLE_BITS)) u_state (
        .c(c), .rst(rst), .en(1'b1), .d(state_next), .q(state_bits)
    );

    r #(.WIDTH(8)) u_shift (
        .c(c), .rst(rst), .en(shift_en), .d(shift_next), .q(shift_reg)
    );

    r #(.WIDTH(2)) u_cnt (
        .c(c), .rst(rst), .en(1'b1), .d(cnt_next), .q(cnt_reg)
    );

    r #(.WIDTH(8)) u_d (
        .c(c), .rst(rst), .en(byte_done), .d(shift_next), .q(d)
    );

    r #(.WIDTH(1)) u_dv (
        .c(c), .rst(rst), .en(1'b1), .d(byte_done), .q(dv)
    );

    r #(.WIDTH(1)) u_erx (
        .c(c), .rst(rst), .en(1'b1), .d(erx_next), .q(erx)
    );

    // Resets high so a carrier already present at reset release is ignored.
    r #(.WIDTH(1), .RST_VAL(1'b1)) u_rxdv_prev (
        .c(c), .rst(rst), .en(1'b1), .d(phy_rxdv), .q(rxdv_prev_reg)
    );

endmodule

// File: tb/tb_eth_rx.sv
// Randomized and directed bench for eth_rx, checked cycle by cycle against a
// frame-level model derived from the dibit stream.
module tb_eth_rx;

    logic       c;
    logic       rst;
    logic [1:0] phy_rxd;
    logic       phy_rxdv;
    logic [7:0] d;
    logic       dv;
    logic       erx;

    int vectors     = 0;
    int miscompares = 0;

    logic       sdv[$];
    logic [1:0] sd[$];
    logic [7:0] fb[$];

    bit         exp_dv[];
    bit         exp_erx[];
    logic [7:0] exp_b[];
    logic [7:0] exp_hold;

    eth_rx dut (
        .c(c), .rst(rst), .phy_rxd(phy_rxd), .phy_rxdv(phy_rxdv),
        .d(d), .dv(dv), .erx(erx)
    );

    initial c = 1'b0;
    always #10 c = ~c;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    task automatic push(input logic v, input logic [1:0] dd);
        sdv.push_back(v);
        sd.push_back(dd);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) push(1'b1, b[2*k +: 2]);
    endtask

    // Frame = lead-in 00s, preamble dibits, optional SFD + bytes in fb,
    // trailing partial dibits, then 'gap' carrier-low cycles.
    task automatic add_frame(input int lead00, input int pre, input bit noisy,
                             input bit sfd, input int extra, input int gap);
        logic [1:0] nd;
        for (int k = 0; k < lead00; k++) push(1'b1, 2'b00);
        for (int k = 0; k < pre; k++) begin
            nd = noisy ? 2'($urandom_range(0, 2)) : 2'b01;
            push(1'b1, nd);
        end
        if (sfd) begin
            push(1'b1, 2'b11);
            foreach (fb[k]) push_byte(fb[k]);
            for (int k = 0; k < extra; k++) push(1'b1, 2'($urandom_range(0, 3)));
        end
        for (int k = 0; k < gap; k++) push(1'b0, 2'b00);
        fb.delete();
    endtask

    // Expected outputs: every carrier run that begins after a low sample is a
    // frame; its first dibit only wakes the receiver, the first later 11 is
    // the SFD, and each full group of 4 dibits after it is one byte, visible
    // right after the clock that samples its last dibit. erx follows the
    // sample where carrier drops, only if an SFD was seen.
    task automatic build_expect(input bit prev_high);
        int n, i, e, sfd, ndat, k;
        bit prev;
        n = sdv.size();
        exp_dv  = new[n];
        exp_erx = new[n];
        exp_b   = new[n];
        for (int j = 0; j < n; j++) begin
            exp_dv[j] = 0; exp_erx[j] = 0; exp_b[j] = 8'h00;
        end
        prev = prev_high;
        i = 0;
        while (i < n) begin
            if (sdv[i] && !prev) begin
                e = i;
                while (e < n && sdv[e]) e++;
                sfd = -1;
                for (int j = i + 1; j < e; j++) begin
                    if (sd[j] == 2'b11) begin
                        sfd = j;
                        break;
                    end
                end
                if (sfd >= 0) begin
                    ndat = e - sfd - 1;
                    for (int b = 0; b < ndat / 4; b++) begin
                        k = sfd + 1 + 4 * b;
                        exp_dv[k + 3] = 1;
                        exp_b[k + 3]  = {sd[k + 3], sd[k + 2], sd[k + 1], sd[k]};
                    end
                    if (e < n) exp_erx[e] = 1;
                end
                prev = 0;
                i = e + 1;
            end else begin
                prev = sdv[i];
                i++;
            end
        end
    endtask

    task automatic apply_segment(input string name);
        int nbytes = 0;
        for (int i = 0; i < sdv.size(); i++) begin
            @(negedge c);
            phy_rxdv = sdv[i];
            phy_rxd  = sd[i];
            @(posedge c);
            #1;
            if (exp_dv[i]) begin
                exp_hold = exp_b[i];
                nbytes++;
            end
            check("dv", {7'd0, dv}, {7'd0, exp_dv[i]});
            check("erx", {7'd0, erx}, {7'd0, exp_erx[i]});
            check("d", d, exp_hold);
            if (dv) $display("%s: byte %h at cycle %0d", name, d, i);
            if (erx) $display("%s: end of frame at cycle %0d", name, i);
        end
        $display("%s: %0d cycles, %0d bytes expected", name, sdv.size(), nbytes);
        sdv.delete();
        sd.delete();
    endtask

    initial begin
        rst      = 1'b1;
        phy_rxdv = 1'b0;
        phy_rxd  = 2'b00;
        exp_hold = 8'h00;
        #25;
        check("rst_d", d, 8'h00);
        check("rst_dv", {7'd0, dv}, 8'd0);
        check("rst_erx", {7'd0, erx}, 8'd0);
        @(negedge c);
        rst = 1'b0;

        // Directed scenarios.
        push(1'b0, 2'b00);
        fb = '{8'h12, 8'h34};
        add_frame(0, 31, 0, 1, 0, 2);
        fb = '{8'hA5};
        add_frame(2, 31, 0, 1, 0, 2);
        fb = '{8'h3C};
        add_frame(0, 31, 0, 1, 2, 2);
        add_frame(0, 20, 0, 0, 0, 2);
        build_expect(1'b0);
        apply_segment("directed");

        // Two 64-byte frames with a single low cycle between them.
        push(1'b0, 2'b00);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 64; k++) fb.push_back(8'($urandom));
            add_frame(0, 31, 0, 1, 0, 1);
        end
        push(1'b0, 2'b00);
        build_expect(1'b0);
        apply_segment("long");

        // Random frames: noisy preambles, aborts, partial tails, short gaps.
        push(1'b0, 2'b00);
        for (int f = 0; f < 14; f++) begin
            int nb;
            nb = $urandom_range(0, 9);
            for (int k = 0; k < nb; k++) fb.push_back(8'($urandom));
            add_frame($urandom_range(0, 3), $urandom_range(1, 31), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(1, 3));
        end
        build_expect(1'b0);
        apply_segment("random");

        // Reset in the middle of a byte, with carrier still present.
        push(1'b0, 2'b00);
        fb = '{8'h5A, 8'hC3};
        add_frame(0, 31, 0, 1, 2, 0);
        build_expect(1'b0);
        apply_segment("pre_reset");
        #4;
        rst = 1'b1;
        #1;
        exp_hold = 8'h00;
        check("async_rst_d", d, 8'h00);
        check("async_rst_dv", {7'd0, dv}, 8'd0);
        check("async_rst_erx", {7'd0, erx}, 8'd0);
        @(posedge c);
        @(negedge c);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) push(1'b1, 2'($urandom_range(0, 3)));
        push(1'b0, 2'b00);
        for (int k = 0; k < 5; k++) fb.push_back(8'($urandom));
        add_frame(0, 31, 0, 1, 0, 2);
        build_expect(1'b1);
        apply_segment("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
